fetch_stage: RTL

- Instruction-fetch stage of the 16-bit pipelined CPU.
- Owns the program counter and issues word-aligned fetches to the instruction memory/cache over a ready handshake.
- Computes the next PC as PC+2 or the redirect target, and drives the IF/ID pipeline register consumed by decode.
- Handles stall, flush/redirect, cache-miss waits and HLT detection.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_stage_ifid_reg.sv | 39 +++
 rtl/fetch_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage: state encoding,
// the 16-bit machine word, and the reset/halt/bubble constants.
package fetch_pkg;

  typedef logic [15:0] word_t;

  localparam word_t      RESET_PC_DEF  = 16'h0000;
  localparam logic [3:0] HALT_OPC_DEF  = 4'hF;
  localparam word_t      NOP_INSTR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_MISS  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // Instructions are halfword aligned; bit 0 of any target is dropped.
  function automatic word_t align_pc(input word_t addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load captures a fetched instruction, flush turns the
// slot into a bubble, neither holds it. Flush wins over load.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  flush,
  input  word_t d_instr,
  input  word_t d_pc,
  input  word_t d_pc_plus2,
  output logic  q_valid,
  output word_t q_instr,
  output word_t q_pc,
  output word_t q_pc_plus2
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid    <= 1'b0;
      q_instr    <= NOP_INSTR;
      q_pc       <= '0;
      q_pc_plus2 <= '0;
    end else if (flush) begin
      // The pc fields are meaningless in a bubble, so they are left alone.
      q_valid <= 1'b0;
      q_instr <= NOP_INSTR;
    end else if (load) begin
      q_valid    <= 1'b1;
      q_instr    <= d_instr;
      q_pc       <= d_pc;
      q_pc_plus2 <= d_pc_plus2;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests one halfword per cycle from
// imem, and fills IF/ID, honouring redirect > stall > accept and HLT.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter word_t      RESET_PC  = RESET_PC_DEF,
  parameter logic [3:0] HALT_OPC  = HALT_OPC_DEF,
  parameter word_t      NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         redirect_valid,
  input  word_t        redirect_pc,
  output logic         imem_req,
  output word_t        imem_addr,
  input  logic         imem_ready,
  input  word_t        imem_rdata,
  output logic         ifid_valid,
  output word_t        ifid_instr,
  output word_t        ifid_pc,
  output word_t        ifid_pc_plus2,
  output logic         halted,
  output fetch_state_e dbg_state
);

  // Handshake: a fetch completes on a cycle where imem_req && imem_ready are
  // both high; imem_addr is held stable while imem_req waits for imem_ready,
  // and a completed fetch is consumed only when neither stall nor redirect.

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  logic         accept;
  logic         is_hlt;
  logic         ifid_load;
  logic         ifid_flush;

  assign imem_req  = rst_n && (state_q != ST_HALT);
  assign imem_addr = pc_q;
  assign halted    = (state_q == ST_HALT);
  assign dbg_state = state_q;

  assign accept = imem_req && imem_ready && !stall && !redirect_valid;
  assign is_hlt = (imem_rdata[15:12] == HALT_OPC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (redirect_valid) begin
      // A redirect is older than anything in fetch, including a pending miss or HLT.
      pc_d       = align_pc(redirect_pc);
      state_d    = ST_FETCH;
      ifid_flush = 1'b1;
    end else if (!stall) begin
      unique case (state_q)
        ST_FETCH, ST_MISS: begin
          if (accept) begin
            ifid_load = 1'b1;
            if (is_hlt) begin
              state_d = ST_HALT;
            end else begin
              pc_d    = pc_q + 16'd2;
              state_d = ST_FETCH;
            end
          end else begin
            ifid_flush = 1'b1;
            state_d    = ST_MISS;
          end
        end
        ST_HALT: begin
          ifid_flush = 1'b1;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ifid_load),
    .flush      (ifid_flush),
    .d_instr    (imem_rdata),
    .d_pc       (pc_q),
    .d_pc_plus2 (pc_q + 16'd2),
    .q_valid    (ifid_valid),
    .q_instr    (ifid_instr),
    .q_pc       (ifid_pc),
    .q_pc_plus2 (ifid_pc_plus2)
  );

endmodule
